pwm_cfg_ctrl: RTL
=================

Name: pwm_cfg_ctrl

Overview:
- SPI-slave configuration controller that sequences writes into the PWM peripheral's control registers.
- Samples the asynchronous SPI pins (SCLK, nCS, COPI) in the system clock domain and assembles 16-bit write frames.
- Commits each valid frame to one of five 8-bit registers: output enables, PWM enables and duty cycle.
- Sits between the chip input pins and pwm_peripheral; it replaces the bare SPI_peripheral hookup at the top level.

Parameters:
- SYNC_STAGES, 2, flip-flop stages in each pin synchronizer (minimum 2).
- MAX_ADDR, 4, highest writable register address; addresses above it are rejected.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- sclk  input  1  SPI clock pin (ui_in[0]), asynchronous.
- copi  input  1  SPI data pin (ui_in[1]), asynchronous.
- ncs  input  1  SPI chip select pin (ui_in[2]), active-low, asynchronous.
- en_reg_out_7_0  output  8  register 0x00.
- en_reg_out_15_8  output  8  register 0x01.
- en_reg_pwm_7_0  output  8  register 0x02.
- en_reg_pwm_15_8  output  8  register 0x03.
- pwm_duty_cycle  output  8  register 0x04.
- frame_done  output  1  one-cycle pulse when a frame is committed.
- frame_err  output  1  one-cycle pulse when a frame is rejected.
- wr_count  output  8  count of committed writes, wraps 255 -> 0.

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high. All five registers, wr_count, frame_done, frame_err, shifter and bit counter reset to 0. Synchronizer flops reset to idle levels (sclk=0, ncs=1). FSM resets to IDLE.
- Synchronization: each pin passes through SYNC_STAGES flops, plus one extra flop for edge detection.
  - sclk_rise: previous synced sclk = 0 and current = 1.
  - ncs_fall / ncs_rise: edges of synced ncs.
  - copi is sampled from its synced copy on sclk_rise (SPI mode 0).
- Host constraint: SCLK period must be at least 6 clk periods. Behaviour is unspecified above that rate.
- Frame format, MSB first:
  - bit15 = R/W (1 = write).
  - bits14:8 = address.
  - bits7:0 = data.
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: on ncs_fall, clear the shifter and the bit counter, then go to SHIFT. sclk edges are ignored in IDLE.
  - SHIFT: on sclk_rise with synced ncs = 0, shift = {shift[14:0], copi_sync}. The 5-bit counter increments and saturates at 31. On ncs_rise, go to COMMIT.
  - SHIFT, simultaneous events: if sclk_rise and ncs_rise occur in the same cycle, ncs_rise wins and the sclk edge is discarded.
  - COMMIT (exactly one cycle), valid frame: valid = (count == 16) and shift[15] = 1 and shift[14:8] <= MAX_ADDR. If valid, write shift[7:0] to the addressed register, pulse frame_done and increment wr_count.
  - COMMIT, rejected frame: if the frame is not valid and count != 0, pulse frame_err. Causes: wrong length, read bit, or bad address. No register changes.
  - COMMIT, empty frame: if count == 0, neither pulse fires.
  - COMMIT always returns to IDLE.
- Latency: a register update and its frame_done are visible on the clk edge that ends the COMMIT cycle. That is SYNC_STAGES+2 clk edges after the first edge that samples the ncs pin high.
- Register stability: registers hold their value between commits. pwm_peripheral sees only whole-byte updates, never partial values.
- Mid-frame reset: rst during SHIFT abandons the frame with no write and no pulses.
  - After reset the FSM needs a fresh ncs_fall before it shifts again.
  - If ncs is still low when rst deasserts, the remainder of that frame is ignored.
- Reads: the read bit (R/W = 0) is not supported; such frames are rejected via frame_err. There is no COPI-to-CIPO echo.

Test Plan:
1. Reset, then ncs low, 16 bits 0x8055, ncs high -> en_reg_out_7_0 = 0x55 and frame_done pulses once. wr_count = 1. All other registers = 0x00.
2. Write 0x84C0 then 0x82F0 back-to-back -> pwm_duty_cycle = 0xC0 and en_reg_pwm_7_0 = 0xF0. wr_count = 2.
3. Frame 0x8A11 (address 0x0A), frame 0x0322 (read bit), and a 15-bit frame -> frame_err pulses three times. Registers are unchanged; wr_count is unchanged.
4. Assert rst after 8 bits of 0x81AA, deassert it while ncs is still low, finish the frame, then send 0x8133 -> en_reg_out_15_8 = 0x33. 0xAA is never written and no frame_err fires for the aborted frame.
5. Send 256 valid writes -> wr_count wraps to 0. The last data byte is held in its target register.
6. ncs toggles low then high with no SCLK -> no frame_done, no frame_err, no state change.

Source files
------------

// File: rtl/pwm_cfg_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_cfg_ctrl
// Description : SPI-slave (mode 0, write-only) front end that commits 16-bit
//               frames into the five PWM peripheral control registers.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_cfg_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_ADDR    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_done,
  output logic       frame_err,
  output logic [7:0] wr_count
);

  localparam logic [1:0] c_st_idle   = 2'd0;
  localparam logic [1:0] c_st_shift  = 2'd1;
  localparam logic [1:0] c_st_commit = 2'd2;
  localparam logic [6:0] c_max_addr  = 7'(MAX_ADDR);
  localparam logic [4:0] c_frame_len = 5'd16;
  localparam logic [4:0] c_cnt_max   = 5'd31;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_ncs_sync;
  logic [SYNC_STAGES-1:0] r_copi_sync;
  logic                   r_sclk_prev;
  logic                   r_ncs_prev;
  logic [SYNC_STAGES:0]   r_ncs_live;

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [15:0] r_shift;
  logic [4:0]  r_cnt;
  logic [7:0]  r_reg0, r_reg1, r_reg2, r_reg3, r_reg4;
  logic        r_frame_done;
  logic        r_frame_err;
  logic [7:0]  r_wr_count;

  logic w_sclk_s, w_ncs_s, w_copi_s;
  logic w_sclk_rise, w_ncs_fall, w_ncs_rise;
  logic w_clear, w_shift_en, w_valid, w_wr_en, w_reject;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk_sync <= '0;
      r_ncs_sync  <= '1;
      r_copi_sync <= '0;
      r_sclk_prev <= 1'b0;
      r_ncs_prev  <= 1'b1;
      r_ncs_live  <= '0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
      r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
      r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
      r_ncs_prev  <= r_ncs_sync[SYNC_STAGES-1];
      r_ncs_live  <= {r_ncs_live[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
  assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
  assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
  assign w_ncs_rise  = w_ncs_s & ~r_ncs_prev;
  // A fall only counts once the whole ncs chain holds real pin samples, so a
  // pin still held low across reset cannot look like a fresh frame start.
  assign w_ncs_fall  = r_ncs_live[SYNC_STAGES] & r_ncs_prev & ~w_ncs_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:   if (w_ncs_fall) w_state_nxt = c_st_shift;
      c_st_shift:  if (w_ncs_rise) w_state_nxt = c_st_commit;
      c_st_commit: w_state_nxt = c_st_idle;
      default:     w_state_nxt = c_st_idle;
    endcase
  end

  always_comb begin
    w_clear    = (r_state == c_st_idle) & w_ncs_fall;
    w_shift_en = (r_state == c_st_shift) & w_sclk_rise & ~w_ncs_s & ~w_ncs_rise;
    w_valid    = (r_cnt == c_frame_len) & r_shift[15] & (r_shift[14:8] <= c_max_addr);
    w_wr_en    = (r_state == c_st_commit) & w_valid;
    w_reject   = (r_state == c_st_commit) & ~w_valid & (r_cnt != 5'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift      <= '0;
      r_cnt        <= '0;
      r_reg0       <= '0;
      r_reg1       <= '0;
      r_reg2       <= '0;
      r_reg3       <= '0;
      r_reg4       <= '0;
      r_frame_done <= 1'b0;
      r_frame_err  <= 1'b0;
      r_wr_count   <= '0;
    end else begin
      r_frame_done <= w_wr_en;
      r_frame_err  <= w_reject;
      if (w_clear) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else if (w_shift_en) begin
        r_shift <= {r_shift[14:0], w_copi_s};
        if (r_cnt != c_cnt_max) r_cnt <= r_cnt + 5'd1;
      end
      if (w_wr_en) begin
        r_wr_count <= r_wr_count + 8'd1;
        case (r_shift[14:8])
          7'd0:    r_reg0 <= r_shift[7:0];
          7'd1:    r_reg1 <= r_shift[7:0];
          7'd2:    r_reg2 <= r_shift[7:0];
          7'd3:    r_reg3 <= r_shift[7:0];
          7'd4:    r_reg4 <= r_shift[7:0];
          default: ;
        endcase
      end
    end
  end

  assign en_reg_out_7_0  = r_reg0;
  assign en_reg_out_15_8 = r_reg1;
  assign en_reg_pwm_7_0  = r_reg2;
  assign en_reg_pwm_15_8 = r_reg3;
  assign pwm_duty_cycle  = r_reg4;
  assign frame_done      = r_frame_done;
  assign frame_err       = r_frame_err;
  assign wr_count        = r_wr_count;

endmodule
`default_nettype wire
